// File: rtl/vram_pkg.sv
// Shared VRAM geometry and arbiter types.
// The tile-map fetch logic also imports this package.
package vram_pkg;
  localparam int TILES_H        = 25;
  localparam int TILES_V        = 18;
  localparam int TILES_PER_WORD = 16;
  localparam int VRAM_DEPTH     = (TILES_H * TILES_V + TILES_PER_WORD - 1) / TILES_PER_WORD;
  localparam int VRAM_AW        = $clog2(VRAM_DEPTH);

  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_e;
  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

  // Read-return tag: who gets the data and whether the slot returns zero.
  typedef struct packed {
    owner_e owner;
    logic   zero;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{owner: OWN_NONE, zero: 1'b0};
endpackage

// File: rtl/vram_arbiter_if.sv
// CPU memory-mapped bus into the VRAM arbiter.
// master = CPU side, slave = arbiter side.
interface vram_arbiter_if #(
  parameter int AW = vram_pkg::VRAM_AW
);
  import vram_pkg::*;

  logic          cpu_valid;
  logic          cpu_ready;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rvalid, cpu_rdata
  );

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rvalid, cpu_rdata
  );
endinterface

// File: rtl/vram_clear_seq.sv
// Hardware clear sequencer: walks every VRAM word writing a latched fill value.
// A stall (video slot) holds the counter so no address is skipped.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int DEPTH = VRAM_DEPTH,
  parameter int AW    = VRAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stall_i,
  input  logic [31:0]   value_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          wr_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [31:0]   wr_data_o
);
  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic [31:0]   value_q;
  logic          done_q;
  logic          last;

  assign last = (cnt_q == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            value_q <= value_i;
          end
        end
        ST_CLEAR: begin
          if (!stall_i) begin
            cnt_q <= cnt_q + AW'(1);
            if (last) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == ST_CLEAR);
  assign done_o    = done_q;
  assign wr_o      = (state_q == ST_CLEAR) && !stall_i;
  assign wr_addr_o = cnt_q;
  assign wr_data_o = value_q;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch > clear write > CPU, with a
// two-stage tag pipeline steering RAM read data back to its requester.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DEPTH = VRAM_DEPTH,
  parameter int AW    = VRAM_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  vram_arbiter_if.slave       cpu,
  input  logic                vid_req,
  input  logic [AW-1:0]       vid_addr,
  output logic                vid_rvalid,
  output logic [31:0]         vid_rdata,
  input  logic                clr_start,
  input  logic [31:0]         clr_value,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [31:0]         ram_wdata,
  output logic [3:0]          ram_wstrb,
  input  logic [31:0]         ram_rdata
);
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  logic          clr_wr;
  logic [AW-1:0] clr_addr;
  logic [31:0]   clr_data;
  logic          cpu_hs;

  vram_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (clr_start),
    .stall_i   (vid_req),
    .value_i   (clr_value),
    .busy_o    (clr_busy),
    .done_o    (clr_done),
    .wr_o      (clr_wr),
    .wr_addr_o (clr_addr),
    .wr_data_o (clr_data)
  );

  assign cpu.cpu_ready = !clr_busy && !vid_req && !clr_start;
  assign cpu_hs        = cpu.cpu_valid && cpu.cpu_ready;

  logic          ram_en_d, ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [31:0]   ram_wdata_d;
  logic [3:0]    ram_wstrb_d;
  rd_tag_t       tag_d;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_wstrb_d = '0;
    tag_d       = TAG_IDLE;
    if (vid_req) begin
      ram_en_d    = in_range(vid_addr);
      ram_addr_d  = vid_addr;
      tag_d.owner = OWN_VID;
      tag_d.zero  = !in_range(vid_addr);
    end else if (clr_wr) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = clr_addr;
      ram_wdata_d = clr_data;
      ram_wstrb_d = 4'hF;
    end else if (cpu_hs) begin
      // Out-of-range accesses are accepted but never reach the RAM.
      ram_en_d    = in_range(cpu.cpu_addr);
      ram_we_d    = cpu.cpu_we && in_range(cpu.cpu_addr);
      ram_addr_d  = cpu.cpu_addr;
      ram_wdata_d = cpu.cpu_wdata;
      ram_wstrb_d = cpu.cpu_wstrb;
      if (!cpu.cpu_we) begin
        tag_d.owner = OWN_CPU;
        tag_d.zero  = !in_range(cpu.cpu_addr);
      end
    end
  end

  logic          ram_en_q, ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [31:0]   ram_wdata_q;
  logic [3:0]    ram_wstrb_q;
  rd_tag_t       tag_p0_q, tag_p1_q;

  // Stage p0: RAM port registered; stage p1: RAM data returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wstrb_q <= '0;
      tag_p0_q    <= TAG_IDLE;
      tag_p1_q    <= TAG_IDLE;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      tag_p0_q    <= tag_d;
      tag_p1_q    <= tag_p0_q;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wstrb = ram_wstrb_q;

  assign vid_rvalid     = (tag_p1_q.owner == OWN_VID);
  assign vid_rdata      = (vid_rvalid && !tag_p1_q.zero) ? ram_rdata : 32'h0;
  assign cpu.cpu_rvalid = (tag_p1_q.owner == OWN_CPU);
  assign cpu.cpu_rdata  = (cpu.cpu_rvalid && !tag_p1_q.zero) ? ram_rdata : 32'h0;
endmodule
